// File: rtl/dmni_brlite_svc_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmni_brlite_svc_rx : receive FIFO for BrLite service records into the DMNI |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module dmni_brlite_svc_rx #(
    parameter int BUFFER_SIZE  = 8,
    parameter bit IRQ_ON_RESET = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rx_valid_i,
    output logic                           rx_ready_o,
    input  logic [71:0]                    rx_data_i,
    input  logic                           pop_i,
    input  logic                           irq_en_i,
    input  logic                           irq_en_we_i,
    input  logic                           ovf_clr_i,
    output logic                           head_valid_o,
    output logic [31:0]                    head_payload_o,
    output logic [15:0]                    head_seq_source_o,
    output logic [15:0]                    head_producer_o,
    output logic [7:0]                     head_ksvc_o,
    output logic [$clog2(BUFFER_SIZE):0]   count_o,
    output logic                           full_o,
    output logic                           underflow_o,
    output logic                           stall_o,
    output logic                           irq_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [71:0]      mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, stall_q;
    logic             irq_en_q, irq_en_d;
    logic             irq_q;

    logic             full_w, empty_w, push_w, pop_w;
    logic [71:0]      head_w;

    assign full_w  = (count_q == CNT_W'(BUFFER_SIZE));
    assign empty_w = (count_q == '0);
    // Both handshake qualifiers come from registered state only.
    assign push_w  = rx_valid_i && !full_w;
    assign pop_w   = pop_i && !empty_w;

    always_comb begin
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign irq_en_d = irq_en_we_i ? irq_en_i : irq_en_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            stall_q     <= 1'b0;
            irq_en_q    <= IRQ_ON_RESET;
            irq_q       <= 1'b0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            // A new error event takes priority over a clear in the same cycle.
            if (pop_i && empty_w) begin
                underflow_q <= 1'b1;
            end else if (ovf_clr_i) begin
                underflow_q <= 1'b0;
            end
            if (rx_valid_i && full_w) begin
                stall_q <= 1'b1;
            end else if (ovf_clr_i) begin
                stall_q <= 1'b0;
            end
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d && (count_d != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_w && !rst_i) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    assign head_w            = mem_q[rd_ptr_q];
    assign head_payload_o    = head_w[71:40];
    assign head_seq_source_o = head_w[39:24];
    assign head_producer_o   = head_w[23:8];
    assign head_ksvc_o       = head_w[7:0];

    assign rx_ready_o   = !full_w;
    assign head_valid_o = !empty_w;
    assign count_o      = count_q;
    assign full_o       = full_w;
    assign underflow_o  = underflow_q;
    assign stall_o      = stall_q;
    assign irq_o        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_dmni_brlite_svc_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmni_brlite_svc_rx : directed self-checking bench for dmni_brlite_svc_rx |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dmni_brlite_svc_rx;

    localparam int BUFFER_SIZE = 8;

    logic        clk_i = 1'b0;
    logic        rst_i, rx_valid_i, rx_ready_o, pop_i;
    logic [71:0] rx_data_i;
    logic        irq_en_i, irq_en_we_i, ovf_clr_i;
    logic        head_valid_o, full_o, underflow_o, stall_o, irq_o;
    logic [31:0] head_payload_o;
    logic [15:0] head_seq_source_o, head_producer_o;
    logic [7:0]  head_ksvc_o;
    logic [3:0]  count_o;

    int n_vec = 0;
    int n_bad = 0;

    dmni_brlite_svc_rx #(.BUFFER_SIZE(BUFFER_SIZE), .IRQ_ON_RESET(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
        .pop_i(pop_i), .irq_en_i(irq_en_i), .irq_en_we_i(irq_en_we_i),
        .ovf_clr_i(ovf_clr_i), .head_valid_o(head_valid_o),
        .head_payload_o(head_payload_o), .head_seq_source_o(head_seq_source_o),
        .head_producer_o(head_producer_o), .head_ksvc_o(head_ksvc_o),
        .count_o(count_o), .full_o(full_o), .underflow_o(underflow_o),
        .stall_o(stall_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [71:0] mk(input logic [31:0] p);
        mk = {p, p[15:0] ^ 16'hA5A5, ~p[15:0], p[7:0]};
    endfunction

    initial begin
        rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0; pop_i = 1'b0;
        irq_en_i = 1'b0; irq_en_we_i = 1'b0; ovf_clr_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_ready", rx_ready_o, 1);
        chk("rst_hv", head_valid_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_cnt", count_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_uf", underflow_o, 0);
        chk("rst_stall", stall_o, 0);

        // Single push with interrupts enabled
        irq_en_i = 1'b1; irq_en_we_i = 1'b1; tick(); irq_en_we_i = 1'b0;
        chk("irq_idle", irq_o, 0);
        rx_valid_i = 1'b1;
        rx_data_i = {32'hDEADBEEF, 16'h0003, 16'h0102, 8'h05};
        tick(); rx_valid_i = 1'b0;
        chk("t1_hv", head_valid_o, 1);
        chk("t1_pay", head_payload_o, 32'hDEADBEEF);
        chk("t1_seq", head_seq_source_o, 16'h0003);
        chk("t1_prod", head_producer_o, 16'h0102);
        chk("t1_ksvc", head_ksvc_o, 8'h05);
        chk("t1_cnt", count_o, 1);
        chk("t1_irq", irq_o, 1);
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        chk("t1_cnt0", count_o, 0);
        chk("t1_irq0", irq_o, 0);

        // Fill to full, stall, pop admits the held record on the next cycle
        for (int i = 1; i <= 8; i++) begin
            rx_valid_i = 1'b1; rx_data_i = mk(i); tick();
        end
        chk("t2_full", full_o, 1);
        chk("t2_ready", rx_ready_o, 0);
        chk("t2_cnt8", count_o, 8);
        rx_data_i = mk(9); tick();
        chk("t2_stall", stall_o, 1);
        chk("t2_cnt_held", count_o, 8);
        chk("t2_head1", head_payload_o, 1);
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        chk("t2_cnt7", count_o, 7);
        chk("t2_notfull", full_o, 0);
        tick(); rx_valid_i = 1'b0;
        chk("t2_cnt8b", count_o, 8);
        for (int i = 2; i <= 9; i++) begin
            chk("t2_order", head_w_all(), mk(i));
            pop_i = 1'b1; tick(); pop_i = 1'b0;
        end
        chk("t2_empty", head_valid_o, 0);
        ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
        chk("t2_stall_clr", stall_o, 0);

        // Streaming push+pop at count 3 across pointer wrap
        for (int i = 10; i <= 12; i++) begin
            rx_valid_i = 1'b1; rx_data_i = mk(i); tick();
        end
        for (int k = 0; k < 20; k++) begin
            chk("t3_head", head_w_all(), mk(10 + k));
            rx_valid_i = 1'b1; pop_i = 1'b1; rx_data_i = mk(13 + k); tick();
            chk("t3_cnt", count_o, 3);
        end
        rx_valid_i = 1'b0;
        for (int i = 30; i <= 32; i++) begin
            chk("t3_drain", head_w_all(), mk(i));
            pop_i = 1'b1; tick();
        end
        pop_i = 1'b0;
        chk("t3_cnt0", count_o, 0);

        // Underflow behaviour
        pop_i = 1'b1; tick(); pop_i = 1'b0;
        chk("t4_uf", underflow_o, 1);
        chk("t4_cnt", count_o, 0);
        ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
        chk("t4_uf_clr", underflow_o, 0);
        pop_i = 1'b1; ovf_clr_i = 1'b1; tick(); pop_i = 1'b0; ovf_clr_i = 1'b0;
        chk("t4_set_wins", underflow_o, 1);
        ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
        rx_valid_i = 1'b1; pop_i = 1'b1; rx_data_i = mk(77); tick();
        rx_valid_i = 1'b0; pop_i = 1'b0;
        chk("t4_pp_cnt", count_o, 1);
        chk("t4_pp_uf", underflow_o, 1);
        chk("t4_pp_head", head_payload_o, 77);
        pop_i = 1'b1; ovf_clr_i = 1'b1; tick(); pop_i = 1'b0; ovf_clr_i = 1'b0;
        chk("t4_uf_clr2", underflow_o, 0);

        // Interrupt enable gating
        irq_en_i = 1'b0; irq_en_we_i = 1'b1; tick(); irq_en_we_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid_i = 1'b1; rx_data_i = mk(60 + i); tick();
            rx_valid_i = 1'b0;
            chk("t5_irq_off", irq_o, 0);
        end
        irq_en_i = 1'b1; irq_en_we_i = 1'b1; tick(); irq_en_we_i = 1'b0;
        chk("t5_irq_on", irq_o, 1);
        pop_i = 1'b1; tick();
        chk("t5_irq_pop1", irq_o, 1);
        tick(); pop_i = 1'b0;
        chk("t5_irq_pop2", irq_o, 0);

        // Reset mid-stream with a push presented
        for (int i = 40; i <= 44; i++) begin
            rx_valid_i = 1'b1; rx_data_i = mk(i); tick();
        end
        chk("t6_cnt5", count_o, 5);
        rst_i = 1'b1; rx_data_i = mk(99); tick();
        rst_i = 1'b0; rx_valid_i = 1'b0;
        chk("t6_cnt", count_o, 0);
        chk("t6_hv", head_valid_o, 0);
        chk("t6_ready", rx_ready_o, 1);
        chk("t6_irq", irq_o, 0);
        rx_valid_i = 1'b1; rx_data_i = mk(50); tick(); rx_valid_i = 1'b0;
        chk("t6_cnt1", count_o, 1);
        chk("t6_head", head_payload_o, 50);
        chk("t6_irq_en_rst", irq_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic logic [71:0] head_w_all();
        head_w_all = {head_payload_o, head_seq_source_o, head_producer_o, head_ksvc_o};
    endfunction

endmodule
`default_nettype wire
